i2c_slv: RTL and testbench



---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_sync_edge.sv | 45 ++++
 rtl/i2c_slv.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_slv.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: one-hot FSM states, bus ACK/NACK
// levels and the register-file read latency.
// Latency: n/a (types and constants only). Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [10:0] {
        ST_IDLE     = 11'b000_0000_0001,
        ST_DEV      = 11'b000_0000_0010,
        ST_DEV_ACK  = 11'b000_0000_0100,
        ST_ADDR_H   = 11'b000_0000_1000,
        ST_ADDR_L   = 11'b000_0001_0000,
        ST_ADDR_ACK = 11'b000_0010_0000,
        ST_WR       = 11'b000_0100_0000,
        ST_WR_ACK   = 11'b000_1000_0000,
        ST_RD       = 11'b001_0000_0000,
        ST_RD_ACK   = 11'b010_0000_0000,
        ST_WAIT     = 11'b100_0000_0000
    } state_t;

    // SDA level seen on the bus during the acknowledge bit.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // reg_rdata is valid this many clocks after reg_re.
    localparam int RD_LAT = 1;

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-FF synchronizer plus one edge register for SCL/SDA; decodes bus events.
// Latency: 2 clk to the synced level, event pulses are combinational from it.
// Backpressure: none; every pulse is exactly one clk wide.
// Ports: clk, rst (async active-high), scl/sda raw pins in; scl_rise, scl_fall,
//        start (SDA fall with SCL high), stop (SDA rise with SCL high), sda_sync out.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_sync
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_d;
    logic       sda_d;

    // Reset to the idle bus level so leaving reset never fakes a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl};
            sda_ff <= {sda_ff[0], sda};
            scl_d  <= scl_ff[1];
            sda_d  <= sda_ff[1];
        end
    end

    assign scl_rise = scl_ff[1] & ~scl_d;
    assign scl_fall = ~scl_ff[1] & scl_d;
    // SCL must be high on both samples so an SCL edge is never read as START/STOP.
    assign start    = scl_ff[1] & scl_d & sda_d & ~sda_ff[1];
    assign stop     = scl_ff[1] & scl_d & ~sda_d & sda_ff[1];
    assign sda_sync = sda_ff[1];

endmodule

// File: rtl/i2c_slv.sv
// I2C target bridging bus byte-write / random-read / sequential-read onto a register port.
// Latency: 3 clk pin-to-detect; SDA changes 1 clk after a detected SCL fall.
// Backpressure: none; the master paces everything, register port must answer in RD_LAT clk.
// Ports: clk, rst (async active-high), scl in, sda open-drain inout,
//        reg_addr/reg_wdata/reg_we/reg_re/reg_rdata register port, busy status.
// Build option: define I2C_SLV_ADDR16_EN for a two-byte register pointer
//        (default: one pointer byte, reg_addr[15:8] cleared on load).
module i2c_slv
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic              scl_rise;
    logic              scl_fall;
    logic              start;
    logic              stop;
    logic              sda_in;
    logic              sda_oe;
    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              rw;
    logic              addr_lo;
    logic [RD_LAT-1:0] rd_pipe;
    logic [7:0]        rx_byte;

    i2c_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_sync (sda_in)
    );

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    // Byte as it will look once the current rising-edge bit is shifted in.
    assign rx_byte = {shreg[6:0], sda_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd7;
            shreg     <= 8'h00;
            rw        <= 1'b0;
            addr_lo   <= 1'b0;
            rd_pipe   <= '0;
            sda_oe    <= 1'b0;
            reg_addr  <= 16'h0000;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            rd_pipe <= RD_LAT'({rd_pipe, reg_re});

            // Pointer advances the clk after a write strobe, and right after read data is latched.
            if (reg_we) begin
                reg_addr <= reg_addr + 16'd1;
            end
            if (rd_pipe[RD_LAT-1]) begin
                shreg    <= reg_rdata;
                reg_addr <= reg_addr + 16'd1;
            end

            // START outranks everything, including a coincident SCL fall.
            if (start) begin
                state   <= ST_DEV;
                bit_cnt <= 3'd7;
                sda_oe  <= 1'b0;
            end else if (stop) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                // Receive states shift MSB first; bit_cnt wraps 0 -> 7 ready for the next byte.
                if (scl_rise && (state inside {ST_DEV, ST_ADDR_H, ST_ADDR_L, ST_WR})) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt - 3'd1;
                end

                case (state)
                    ST_IDLE, ST_WAIT: begin
                    end
                    ST_DEV: begin
                        if (scl_rise && bit_cnt == 3'd0) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state <= ST_DEV_ACK;
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                                busy  <= 1'b0;
                            end
                        end
                    end
`ifdef I2C_SLV_ADDR16_EN
                    ST_ADDR_H: begin
                        if (scl_rise && bit_cnt == 3'd0) begin
                            reg_addr[15:8] <= rx_byte;
                            addr_lo        <= 1'b0;
                            state          <= ST_ADDR_ACK;
                        end
                    end
`endif
                    ST_ADDR_L: begin
                        if (scl_rise && bit_cnt == 3'd0) begin
`ifdef I2C_SLV_ADDR16_EN
                            reg_addr[7:0] <= rx_byte;
`else
                            reg_addr <= {8'h00, rx_byte};
`endif
                            addr_lo <= 1'b1;
                            state   <= ST_ADDR_ACK;
                        end
                    end
                    ST_WR: begin
                        if (scl_rise && bit_cnt == 3'd0) begin
                            reg_we    <= 1'b1;
                            reg_wdata <= rx_byte;
                            state     <= ST_WR_ACK;
                        end
                    end
                    // ACK states: first SCL fall pulls SDA low, second one releases and moves on.
                    // The read fetch rides on the ACK bit's rising edge.
                    ST_DEV_ACK: begin
                        if (scl_rise && sda_oe && rw) begin
                            reg_re <= 1'b1;
                        end
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= ~ACK;
                            end else if (rw) begin
                                state   <= ST_RD;
                                bit_cnt <= 3'd7;
                                sda_oe  <= ~shreg[7];
                            end else begin
`ifdef I2C_SLV_ADDR16_EN
                                state <= ST_ADDR_H;
`else
                                state <= ST_ADDR_L;
`endif
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= ~ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ST_WR_ACK || addr_lo) ? ST_WR : ST_ADDR_L;
                            end
                        end
                    end
                    // bit_cnt names the bit currently on SDA; each fall moves to the next one.
                    ST_RD: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= ~NACK;
                                state  <= ST_RD_ACK;
                            end else begin
                                sda_oe <= ~shreg[bit_cnt - 3'd1];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_in == ACK) begin
                                reg_re <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                                busy  <= 1'b0;
                            end
                        end
                        if (scl_fall) begin
                            state   <= ST_RD;
                            bit_cnt <= 3'd7;
                            sda_oe  <= ~shreg[7];
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slv.sv
// Bench for i2c_slv: bit-banged I2C master, register-file model, write/read scoreboard.
// Latency: n/a. Backpressure: n/a.
module tb_i2c_slv;
    import i2c_pkg::*;

    localparam logic [6:0] DEV = 7'b1010000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_pull = 1'b0;
    wire         sda;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata = 8'h00;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    wr_t         sb_w;
    logic [15:0] sb_a;

    assign sda = m_pull ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slv #(.SLAVE_ADDR(DEV)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return (a == 16'h0040) ? 8'h3C : (a[7:0] ^ a[15:8] ^ 8'hC3);
    endfunction

    // Pointer value the target holds after a pointer load in this build.
    function automatic logic [15:0] eff(input logic [15:0] p);
`ifdef I2C_SLV_ADDR16_EN
        return p;
`else
        return {8'h00, p[7:0]};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Register file: read data one clk after the strobe.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem_val(reg_addr);
    end

    // Scoreboard: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && reg_we) begin
            check("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                sb_w = exp_wr.pop_front();
                check("wr_addr", reg_addr, sb_w.addr);
                check("wr_data", reg_wdata, sb_w.data);
            end
        end
        if (!rst && reg_re) begin
            check("rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                sb_a = exp_rd.pop_front();
                check("rd_addr", reg_addr, sb_a);
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_pull = 1'b0; wclk(5);
        scl = 1'b1;    wclk(5);
        m_pull = 1'b1; wclk(5);
        scl = 1'b0;    wclk(5);
    endtask

    task automatic bus_stop();
        m_pull = 1'b1; wclk(5);
        scl = 1'b1;    wclk(5);
        m_pull = 1'b0; wclk(10);
    endtask

    task automatic send_bit(input logic b);
        m_pull = ~b; wclk(5);
        scl = 1'b1;  wclk(10);
        scl = 1'b0;  wclk(5);
    endtask

    task automatic recv_bit(output logic b);
        m_pull = 1'b0; wclk(5);
        scl = 1'b1;    wclk(5);
        b = sda;       wclk(5);
        scl = 1'b0;    wclk(5);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    task automatic set_ptr(input logic [15:0] p);
        logic a;
        bus_start();
        write_byte({DEV, 1'b0}, a); check("dev_w_ack", a, ACK);
`ifdef I2C_SLV_ADDR16_EN
        write_byte(p[15:8], a);     check("ptr_h_ack", a, ACK);
`endif
        write_byte(p[7:0], a);      check("ptr_l_ack", a, ACK);
    endtask

    typedef struct { logic [15:0] ptr; logic [7:0] data; logic [15:0] exp_next; } wvec_t;
    wvec_t wv[4];

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic [7:0]  d;
        logic [15:0] p;

        wv[0] = '{16'h0012, 8'hA5, 16'h0013};
        wv[1] = '{16'h00FF, 8'h5A, 16'h0100};
        wv[2] = '{16'h0080, 8'h00, 16'h0081};
        wv[3] = '{16'h0001, 8'hFF, 16'h0002};

        // Reset state
        wclk(3);
        check("rst_reg_addr", reg_addr, 16'h0000);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_reg_we", reg_we, 0);
        check("rst_reg_re", reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_sda", sda, 1);
        rst = 1'b0;
        wclk(5);

        // Byte writes from the table
        for (int i = 0; i < 4; i++) begin
            set_ptr(wv[i].ptr);
            exp_wr.push_back({wv[i].ptr, wv[i].data});
            write_byte(wv[i].data, a);
            check("data_ack", a, ACK);
            check("busy_in_xfer", busy, 1);
            check("addr_after_wr", reg_addr, wv[i].exp_next);
            bus_stop();
            check("busy_after_stop", busy, 0);
        end

        // Random read with repeated START and master NACK
        set_ptr(16'h0040);
        exp_rd.push_back(eff(16'h0040));
        bus_start();
        write_byte({DEV, 1'b1}, a); check("dev_r_ack", a, ACK);
        read_byte(d, NACK);
        check("rd_data", d, 8'h3C);
        check("busy_after_nack", busy, 0);
        check("sda_released_nack", sda, 1);
        check("addr_after_rd", reg_addr, 16'h0041);
        bus_stop();

        // Wrong device address is ignored, then a correct one is ACKed
        bus_start();
        write_byte({7'h51, 1'b0}, a); check("wrong_addr_nack", a, NACK);
        check("wrong_addr_busy", busy, 0);
        write_byte(8'h77, a);         check("wrong_addr_data_nack", a, NACK);
        bus_stop();
        bus_start();
        write_byte({DEV, 1'b0}, a);   check("after_wrong_ack", a, ACK);
        check("after_wrong_busy", busy, 1);
        bus_stop();

        // Sequential read across the 16-bit pointer wrap
        p = eff(16'hFFFE);
        set_ptr(16'hFFFE);
        exp_rd.push_back(p);
        exp_rd.push_back(p + 16'd1);
        exp_rd.push_back(p + 16'd2);
        bus_start();
        write_byte({DEV, 1'b1}, a); check("seq_dev_ack", a, ACK);
        read_byte(d, ACK);  check("seq_rd0", d, mem_val(p));
        read_byte(d, ACK);  check("seq_rd1", d, mem_val(p + 16'd1));
        read_byte(d, NACK); check("seq_rd2", d, mem_val(p + 16'd2));
        check("seq_addr_after", reg_addr, p + 16'd3);
        bus_stop();

        // STOP four bits into a data byte: no write
        set_ptr(16'h0020);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        check("partial_busy", busy, 0);
        check("partial_sda", sda, 1);
        check("partial_addr", reg_addr, eff(16'h0020));

        // Reset while the target is driving a read bit
        set_ptr(16'h0040);
        exp_rd.push_back(eff(16'h0040));
        bus_start();
        write_byte({DEV, 1'b1}, a); check("rst_rd_dev_ack", a, ACK);
        check("rd_bit7_driven", sda, 0);
        rst = 1'b1;
        wclk(1);
        check("rst_mid_sda", sda, 1);
        check("rst_mid_addr", reg_addr, 16'h0000);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_we", reg_we, 0);
        check("rst_mid_re", reg_re, 0);
        check("rst_mid_wdata", reg_wdata, 8'h00);
        rst = 1'b0;
        wclk(5);
        bus_start();
        write_byte({DEV, 1'b0}, a); check("post_rst_ack", a, ACK);
        bus_stop();

        wclk(10);
        check("sb_wr_drained", exp_wr.size(), 0);
        check("sb_rd_drained", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
